// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RISC-V funct3 size codes, the
// FSM state encoding, the default data-memory size and a helper that maps
// funct3 to an access size in bytes.
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned DEFAULT_ADDR_LIMIT = 8192;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    STORE_HI = 1'b1
  } state_t;

  // Access size in bytes; 0 marks an encoding that is never legal.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      F3_W:        access_size = 3'd4;
      default:     access_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the pipeline request/response handshake and the data-memory bus.
//   slave  : the load/store unit (takes requests, drives the memory)
//   master : the pipeline plus data memory around it
// Optional macro ALIGN_CHECK_EN adds the misaligned response flag.
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            reqValid;
  logic            reqReady;
  logic            reqWrite;
  logic [2:0]      funct3;
  logic [XLEN-1:0] reqAddress;
  logic [XLEN-1:0] reqWriteData;
  logic            respValid;
  logic [XLEN-1:0] loadData;
  logic            fault;
  logic [XLEN-1:0] memAddress;
  logic [XLEN-1:0] memWriteData;
  logic            memWrite;
  logic            sb;
  logic [XLEN-1:0] memReadData;
`ifdef ALIGN_CHECK_EN
  logic            misaligned;
`endif

  modport slave (
    input  reqValid, reqWrite, funct3, reqAddress, reqWriteData, memReadData,
    output reqReady, respValid, loadData, fault,
    output memAddress, memWriteData, memWrite, sb
`ifdef ALIGN_CHECK_EN
    , output misaligned
`endif
  );

  modport master (
    output reqValid, reqWrite, funct3, reqAddress, reqWriteData, memReadData,
    input  reqReady, respValid, loadData, fault,
    input  memAddress, memWriteData, memWrite, sb
`ifdef ALIGN_CHECK_EN
    , input misaligned
`endif
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load extender: selects byte/halfword/word from the memory
// read data and sign- or zero-extends it according to funct3.
//   funct3    : load size/sign code
//   read_data : 4 little-endian bytes read at the access address
//   load_data : extended result (0 for non-load encodings)
// ----------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] read_data,
  output logic [XLEN-1:0] load_data
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = '0;
    case (funct3)
      F3_B:  load_data = {{(XLEN-8){read_data[7]}}, read_data[7:0]};
      F3_BU: load_data = {{(XLEN-8){1'b0}}, read_data[7:0]};
      F3_H:  load_data = {{(XLEN-16){read_data[15]}}, read_data[15:0]};
      F3_HU: load_data = {{(XLEN-16){1'b0}}, read_data[15:0]};
      F3_W:  load_data = read_data;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage: accepts one load or store per request, drives the
// byte-addressed data memory and returns a registered one-cycle response.
// Halfword stores are issued as two byte writes (IDLE then STORE_HI).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request/response handshake and data-memory bus (slave side)
// Optional macro ALIGN_CHECK_EN: misaligned H/W accesses fault with
// bus.misaligned=1 instead of being issued to memory.
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
  parameter int          XLEN       = 32
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  state_t          state, state_nxt;
  logic            ready, accept;
  logic [2:0]      size;
  logic [XLEN:0]   last_byte;
  logic            illegal, out_of_range, misal, req_fault, is_sh;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] hi_addr;
  logic [7:0]      hi_byte;
  logic            resp_q, fault_q;
  logic [XLEN-1:0] load_q;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3    (bus.funct3),
    .read_data (bus.memReadData),
    .load_data (ext_data)
  );

  // Request legality; the range check is done one bit wider so an access
  // wrapping past the top of the address space still faults.
  always_comb begin
    size         = access_size(bus.funct3);
    illegal      = (size == 3'd0) || (bus.reqWrite && bus.funct3[2]);
    last_byte    = {1'b0, bus.reqAddress} + (XLEN+1)'(size) - (XLEN+1)'(1);
    out_of_range = last_byte >= (XLEN+1)'(ADDR_LIMIT);
`ifdef ALIGN_CHECK_EN
    misal = ((size == 3'd2) && bus.reqAddress[0]) ||
            ((size == 3'd4) && (bus.reqAddress[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    req_fault = illegal || out_of_range || misal;
    is_sh     = bus.reqWrite && (bus.funct3 == F3_H);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and memory-side outputs. Reset also blocks acceptance so the
  // memory bus is quiet for the whole time reset is held.
  always_comb begin
    state_nxt        = state;
    ready            = (state == IDLE) && !reset;
    accept           = bus.reqValid && ready;
    bus.memAddress   = '0;
    bus.memWriteData = '0;
    bus.memWrite     = 1'b0;
    bus.sb           = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.memAddress   = bus.reqAddress;
          bus.memWriteData = bus.reqWriteData;
          if (bus.reqWrite && !req_fault) begin
            bus.memWrite = 1'b1;
            bus.sb       = (size != 3'd4);
            if (is_sh) state_nxt = STORE_HI;
          end
        end
      end
      STORE_HI: begin
        bus.memAddress   = hi_addr;
        bus.memWriteData = {{(XLEN-8){1'b0}}, hi_byte};
        bus.memWrite     = 1'b1;
        bus.sb           = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers; loadData and fault hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q  <= 1'b0;
      fault_q <= 1'b0;
      load_q  <= '0;
      hi_addr <= '0;
      hi_byte <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      resp_q <= 1'b0;
      if (state == STORE_HI) begin
        resp_q  <= 1'b1;
        fault_q <= 1'b0;
      end else if (accept) begin
        if (req_fault) begin
          resp_q  <= 1'b1;
          fault_q <= 1'b1;
          load_q  <= '0;
        end else if (is_sh) begin
          hi_addr <= bus.reqAddress + XLEN'(1);
          hi_byte <= bus.reqWriteData[15:8];
        end else begin
          resp_q  <= 1'b1;
          fault_q <= 1'b0;
          if (!bus.reqWrite) load_q <= ext_data;
        end
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  mis_q <= 1'b0;
    else if (state == STORE_HI) mis_q <= 1'b0;
    else if (accept)            mis_q <= misal;
  end

  assign bus.misaligned = mis_q;
`endif

  assign bus.reqReady  = ready;
  assign bus.respValid = resp_q;
  assign bus.fault     = fault_q;
  assign bus.loadData  = load_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between the pipeline's EX/MEM register and the byte-addressed data memory. It accepts one load or store per request and drives the memory's address, write-data, memWrite and sb lines. Load results are sign- or zero-extended per RISC-V funct3. Halfword stores are split into two byte writes because the memory supports only byte and word stores.

Parameters:
ADDR_LIMIT, 8192, data memory size in bytes; accesses touching bytes at or beyond this limit fault.
XLEN, 32, data and address width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
reqValid  input  1  request present.
reqReady  output  1  unit can accept this cycle (high in IDLE).
reqWrite  input  1  1 = store, 0 = load.
funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
reqAddress  input  32  byte address.
reqWriteData  input  32  store data, LSB-aligned.
respValid  output  1  one-cycle completion pulse.
loadData  output  32  extended load result, valid with respValid.
fault  output  1  out-of-range or illegal funct3, valid with respValid.
memAddress  output  32  address to data memory.
memWriteData  output  32  write data to data memory.
memWrite  output  1  write strobe to data memory.
sb  output  1  byte-store select to data memory.
memReadData  input  32  combinational read data from memory (4 bytes from memAddress, little-endian).

Behaviour:
- Reset (async): state=IDLE; respValid=0, loadData=0, fault=0; memWrite=0, sb=0, memAddress=0, memWriteData=0.
- Accept condition: reqValid && reqReady. reqReady=1 only in IDLE.
- Memory-side outputs are combinational from the accepted request in IDLE and from latched registers in STORE_HI. memWrite=0 whenever no write is being issued. Each memWrite pulse lasts exactly one cycle.
- Legality: size = 1/2/4 for B/H/W. Fault if reqAddress+size-1 >= ADDR_LIMIT, or if funct3 is in {011,110,111}, or if a store uses 100/101. On fault: no memWrite; next cycle respValid=1, fault=1, loadData=0.
- Load, any legal size:
  - Accept cycle: memAddress=reqAddress, memWrite=0.
  - memReadData is captured at the clock edge and extended: B sign-extends byte 0; BU zero-extends byte 0; H sign-extends bytes 1:0; HU zero-extends bytes 1:0; W passes through.
  - respValid=1 the next cycle. Latency is 1.
- SB: accept cycle drives memWrite=1, sb=1, memWriteData=reqWriteData. respValid=1 next cycle.
- SW: accept cycle drives memWrite=1, sb=0. respValid=1 next cycle.
- SH:
  - Accept cycle writes byte 0 (memWrite=1, sb=1, memWriteData[7:0]=reqWriteData[7:0]). Next state is STORE_HI.
  - STORE_HI writes reqWriteData[15:8] to address+1 with sb=1. State returns to IDLE, and respValid=1 the following cycle. Latency is 2.
- States:
  - IDLE -> STORE_HI on an accepted legal SH; otherwise IDLE.
  - STORE_HI -> IDLE unconditionally.
  - respValid is registered, one cycle after the last memory cycle or after a fault decision.
- Back-to-back: a new request is accepted in the same cycle respValid is high for the previous one.
- Misaligned addresses are legal by default. The memory handles any byte address.
- Reset in STORE_HI aborts the operation: byte 1 is not written and no respValid is issued.
- loadData and fault hold their value between responses.

Optional Feature:
ALIGN_CHECK_EN. When defined, H/HU/SH with reqAddress[0]!=0, or W/SW with reqAddress[1:0]!=0, are not issued to memory. They complete next cycle with respValid=1, fault=1 and an extra output misaligned=1. When not defined, the misaligned port does not exist and misaligned accesses proceed normally.

Decomposition:
Shared package lsu_pkg holds:
- funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
- state encoding IDLE/STORE_HI;
- ADDR_LIMIT default.

One sub-module, load_extend, is the combinational extender (funct3, memReadData) -> loadData.

Test Plan:
- Memory holds 0xF000F002 at address 4: LB 4 -> 0x00000002; LB 5 -> 0xFFFFFFF0; LH 4 -> 0xFFFFF002; LHU 4 -> 0x0000F002; LW 4 -> 0xF000F002. Each gives respValid exactly 1 cycle after accept.
- SH 0xABCD1234 at 8:
  - Cycle 0: memAddress=8, sb=1, data byte 0x34.
  - Cycle 1: memAddress=9, sb=1, data byte 0x12, reqReady=0.
  - Cycle 2: respValid.
  - Then LW 8 -> 0x00001234.
- SW 0xDEADBEEF at 12, then LBU 15 -> 0x000000DE. Back-to-back issue with no idle cycle.
- Fault cases, each with respValid=1, fault=1 and no memWrite:
  - LW at 8190 (ADDR_LIMIT=8192).
  - Store with funct3=100.
  - Load with funct3=111.
- Assert reset during STORE_HI of SH 0x5566 at 20: byte 21 is unchanged, respValid stays 0, and the outputs take their reset values immediately.
- With ALIGN_CHECK_EN: LW 6 -> respValid, fault=1, misaligned=1, memWrite never high. Without it: LW 6 -> 0x0000F000 (bytes 6..9 with byte 8 = 0, when memory is unwritten).
